control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/control_sequencer_if.sv | 35 +++
 rtl/microcode_rom.sv | 74 +++++++
 rtl/control_sequencer.sv | 77 +++++++
 tb/tb_control_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: control-word layout, bit
// indices, one-hot bit masks and opcode numbers.
package ctrl_pkg;

  localparam int CTRL_W = 16;
  typedef logic [CTRL_W-1:0] ctrl_word_t;

  // Bit order, MSB first: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam ctrl_word_t C_HLT = ctrl_word_t'(1) << B_HLT;
  localparam ctrl_word_t C_MI  = ctrl_word_t'(1) << B_MI;
  localparam ctrl_word_t C_RI  = ctrl_word_t'(1) << B_RI;
  localparam ctrl_word_t C_RO  = ctrl_word_t'(1) << B_RO;
  localparam ctrl_word_t C_IO  = ctrl_word_t'(1) << B_IO;
  localparam ctrl_word_t C_II  = ctrl_word_t'(1) << B_II;
  localparam ctrl_word_t C_AI  = ctrl_word_t'(1) << B_AI;
  localparam ctrl_word_t C_AO  = ctrl_word_t'(1) << B_AO;
  localparam ctrl_word_t C_EO  = ctrl_word_t'(1) << B_EO;
  localparam ctrl_word_t C_SU  = ctrl_word_t'(1) << B_SU;
  localparam ctrl_word_t C_BI  = ctrl_word_t'(1) << B_BI;
  localparam ctrl_word_t C_OI  = ctrl_word_t'(1) << B_OI;
  localparam ctrl_word_t C_CE  = ctrl_word_t'(1) << B_CE;
  localparam ctrl_word_t C_CO  = ctrl_word_t'(1) << B_CO;
  localparam ctrl_word_t C_J   = ctrl_word_t'(1) << B_J;
  localparam ctrl_word_t C_FI  = ctrl_word_t'(1) << B_FI;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LDA = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_STA = 4;
  localparam int unsigned OP_LDI = 5;
  localparam int unsigned OP_JMP = 6;
  localparam int unsigned OP_JC  = 7;
  localparam int unsigned OP_JZ  = 8;
  localparam int unsigned OP_OUT = 14;
  localparam int unsigned OP_HLT = 15;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of run/step controls, bus, flags and the sequencer's outputs.
// ce is a one-clk advance strobe with no back-pressure: every datapath block
// commits on exactly those clk edges where ce=1, and ctrl is stable between them.
interface control_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int MAX_STEPS    = 5
);
  import ctrl_pkg::*;

  localparam int STEP_W = $clog2(MAX_STEPS);

  logic                               tick;
  logic                               step_req;
  logic                               mode;
  logic [DATA_WIDTH-1:0]              bus_in;
  logic                               flag_c;
  logic                               flag_z;
  logic                               ce;
  ctrl_word_t                         ctrl;
  logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand;
  logic [STEP_W-1:0]                  step;
  logic                               halted;

  modport master (
    output tick, step_req, mode, bus_in, flag_c, flag_z,
    input  ce, ctrl, operand, step, halted
  );

  modport slave (
    input  tick, step_req, mode, bus_in, flag_c, flag_z,
    output ce, ctrl, operand, step, halted
  );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, step, flags) to a control word and a
// "last step of this instruction" flag.
module microcode_rom
  import ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_W       = 3
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [STEP_W-1:0]       step,
  input  logic                    flag_c,
  input  logic                    flag_z,
  output ctrl_word_t              ctrl,
  output logic                    last
);

  int unsigned op;
  int unsigned st;

  assign op = 32'(opcode);
  assign st = 32'(step);

  // Steps past an instruction's end read as empty and terminal; opcodes
  // without an entry (including anything >= 16) fall through as NOP.
  always_comb begin
    ctrl = '0;
    last = 1'b1;
    if (st == 0) begin
      ctrl = C_CO | C_MI;
      last = 1'b0;
    end else if (st == 1) begin
      ctrl = C_RO | C_II | C_CE;
      last = 1'b0;
    end else begin
      case (op)
        OP_LDA: begin
          if (st == 2) begin
            ctrl = C_IO | C_MI;
            last = 1'b0;
          end else if (st == 3) begin
            ctrl = C_RO | C_AI;
          end
        end
        OP_ADD, OP_SUB: begin
          if (st == 2) begin
            ctrl = C_IO | C_MI;
            last = 1'b0;
          end else if (st == 3) begin
            ctrl = C_RO | C_BI;
            last = 1'b0;
          end else if (st == 4) begin
            ctrl = C_EO | C_AI | C_FI | ((op == OP_SUB) ? C_SU : '0);
          end
        end
        OP_STA: begin
          if (st == 2) begin
            ctrl = C_IO | C_MI;
            last = 1'b0;
          end else if (st == 3) begin
            ctrl = C_AO | C_RI;
          end
        end
        OP_LDI: if (st == 2) ctrl = C_IO | C_AI;
        OP_JMP: if (st == 2) ctrl = C_IO | C_J;
        OP_JC:  if (st == 2 && flag_c) ctrl = C_IO | C_J;
        OP_JZ:  if (st == 2 && flag_z) ctrl = C_IO | C_J;
        OP_OUT: if (st == 2) ctrl = C_AO | C_OI;
        OP_HLT: if (st == 2) ctrl = C_HLT;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: instruction register, step counter, halt latch and the
// run/single-step advance gating around the microcode ROM.
module control_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int MAX_STEPS    = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  control_sequencer_if.slave  sif
);
  import ctrl_pkg::*;

  localparam int STEP_W = $clog2(MAX_STEPS);
  localparam int OPER_W = DATA_WIDTH - OPCODE_WIDTH;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  if (MAX_STEPS < 3 || MAX_STEPS > 16) begin : g_bad_max_steps
    $error("control_sequencer: MAX_STEPS must lie in 3..16");
  end
  if (OPCODE_WIDTH < 4 || OPCODE_WIDTH >= DATA_WIDTH) begin : g_bad_opcode_width
    $error("control_sequencer: OPCODE_WIDTH must be >= 4 and < DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] ir_q;
  logic [STEP_W-1:0]     step_q;
  logic                  halted_q;
  logic                  req_hist_q;
  logic                  step_pulse;
  logic                  ce;
  ctrl_word_t            rom_ctrl;
  logic                  rom_last;

  microcode_rom #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .STEP_W       (STEP_W)
  ) u_rom (
    .opcode (ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]),
    .step   (step_q),
    .flag_c (sif.flag_c),
    .flag_z (sif.flag_z),
    .ctrl   (rom_ctrl),
    .last   (rom_last)
  );

  // History resets high so a request already held at reset release is ignored.
  assign step_pulse = sif.step_req & ~req_hist_q;
  assign ce         = rst_n & ~halted_q & (sif.mode ? step_pulse : sif.tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= '0;
      step_q     <= '0;
      halted_q   <= 1'b0;
      req_hist_q <= 1'b1;
    end else begin
      req_hist_q <= sif.step_req;
      if (ce) begin
        if (rom_ctrl[B_II]) ir_q <= sif.bus_in;
        if (rom_ctrl[B_HLT]) begin
          halted_q <= 1'b1;
        end else if (rom_last || step_q == STEP_LAST) begin
          step_q <= '0;
        end else begin
          step_q <= step_q + 1'b1;
        end
      end
    end
  end

  assign sif.ce      = ce;
  assign sif.ctrl    = halted_q ? '0 : rom_ctrl;
  assign sif.operand = ir_q[OPER_W-1:0];
  assign sif.step    = step_q;
  assign sif.halted  = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random run/step/reset
// traffic, checked every cycle against an instruction-level model.
module tb_control_sequencer;

  localparam int DW = 8;
  localparam int OW = 4;
  localparam int MS = 5;

  typedef logic [15:0] word_t;

  localparam word_t W_HLT = 16'h8000;
  localparam word_t W_MI  = 16'h4000;
  localparam word_t W_RI  = 16'h2000;
  localparam word_t W_RO  = 16'h1000;
  localparam word_t W_IO  = 16'h0800;
  localparam word_t W_II  = 16'h0400;
  localparam word_t W_AI  = 16'h0200;
  localparam word_t W_AO  = 16'h0100;
  localparam word_t W_EO  = 16'h0080;
  localparam word_t W_SU  = 16'h0040;
  localparam word_t W_BI  = 16'h0020;
  localparam word_t W_OI  = 16'h0010;
  localparam word_t W_CE  = 16'h0008;
  localparam word_t W_CO  = 16'h0004;
  localparam word_t W_J   = 16'h0002;
  localparam word_t W_FI  = 16'h0001;

  logic clk;
  logic rst_n;

  control_sequencer_if #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .MAX_STEPS(MS)) sif();

  control_sequencer #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .MAX_STEPS(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters and check ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Whole microprogram of an instruction (fetch included) as a list of words.
  function automatic word_t prog_word(input int op, input int idx, input bit fc,
                                      input bit fz, output int len);
    word_t p[$];
    p = {W_CO | W_MI, W_RO | W_II | W_CE};
    case (op)
      1:  p = {p, W_IO | W_MI, W_RO | W_AI};
      2:  p = {p, W_IO | W_MI, W_RO | W_BI, W_EO | W_AI | W_FI};
      3:  p = {p, W_IO | W_MI, W_RO | W_BI, W_EO | W_AI | W_SU | W_FI};
      4:  p = {p, W_IO | W_MI, W_AO | W_RI};
      5:  p.push_back(W_IO | W_AI);
      6:  p.push_back(W_IO | W_J);
      7:  p.push_back(fc ? (W_IO | W_J) : 16'h0000);
      8:  p.push_back(fz ? (W_IO | W_J) : 16'h0000);
      14: p.push_back(W_AO | W_OI);
      15: p.push_back(W_HLT);
      default: p.push_back(16'h0000);
    endcase
    len = p.size();
    return (idx < len) ? p[idx] : 16'h0000;
  endfunction

  logic [DW-1:0] m_ir     = '0;
  int            m_step   = 0;
  bit            m_halted = 1'b0;
  bit            m_prev   = 1'b1;

  function automatic bit model_ce();
    bit pulse;
    pulse = sif.step_req && !m_prev;
    return rst_n && !m_halted && (sif.mode ? pulse : sif.tick);
  endfunction

  function automatic word_t model_word(output int len);
    return prog_word(int'(m_ir[DW-1 -: OW]), m_step, sif.flag_c, sif.flag_z, len);
  endfunction

  always @(posedge clk) begin
    int    len;
    word_t w;
    if (!rst_n) begin
      m_ir = '0; m_step = 0; m_halted = 1'b0; m_prev = 1'b1;
    end else begin
      w = model_word(len);
      if (model_ce()) begin
        if ((w & W_II) != 0) m_ir = sif.bus_in;
        if ((w & W_HLT) != 0) m_halted = 1'b1;
        else if (m_step + 1 == len || m_step == MS - 1) m_step = 0;
        else m_step = m_step + 1;
      end
      m_prev = sif.step_req;
    end
  end

  // ---------------- scoreboard: every negedge ----------------
  logic [40:0] exp_q[$];

  always @(negedge clk) begin
    int          len;
    word_t       w;
    logic [40:0] e;
    logic [40:0] a;
    if (!rst_n) begin
      e = {1'b0, 16'h4004, 8'd0, 1'b0, 15'd0};
    end else begin
      w = model_word(len);
      e = {model_ce(), (m_halted ? 16'h0000 : w), 8'(m_step), m_halted, 11'd0, m_ir[DW-OW-1:0]};
    end
    exp_q.push_back(e);
    a = {sif.ce, sif.ctrl, 8'(sif.step), sif.halted, 11'd0, sif.operand};
    e = exp_q.pop_front();
    check("cyc_ce",      32'(a[40]),    32'(e[40]));
    check("cyc_ctrl",    32'(a[39:24]), 32'(e[39:24]));
    check("cyc_step",    32'(a[23:16]), 32'(e[23:16]));
    check("cyc_halted",  32'(a[15]),    32'(e[15]));
    check("cyc_operand", 32'(a[3:0]),   32'(e[3:0]));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One tick, then three idle clocks: tick every 4 clk.
  task automatic adv();
    sif.tick = 1'b1;
    cyc(1);
    sif.tick = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ce_cnt;
    rst_n        = 1'b0;
    sif.tick     = 1'b0;
    sif.step_req = 1'b0;
    sif.mode     = 1'b0;
    sif.bus_in   = '0;
    sif.flag_c   = 1'b0;
    sif.flag_z   = 1'b0;
    cyc(3);

    // Reset state, with tick high to prove ce is held off.
    sif.tick = 1'b1;
    #1;
    check("rst_ce",   32'(sif.ce),   32'h0);
    check("rst_ctrl", 32'(sif.ctrl), 32'h4004);
    sif.tick = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    #1;
    check("rel_ctrl", 32'(sif.ctrl), 32'h4004);
    check("rel_step", 32'(sif.step), 32'h0);

    // LDI 7
    sif.bus_in = 8'h57;
    adv();
    check("fetch1_step", 32'(sif.step), 32'h1);
    check("fetch1_ctrl", 32'(sif.ctrl), 32'h1408);
    adv();
    check("ldi_step",    32'(sif.step),    32'h2);
    check("ldi_ctrl",    32'(sif.ctrl),    32'h0A00);
    check("ldi_operand", 32'(sif.operand), 32'h7);
    adv();
    check("ldi_wrap",    32'(sif.step),    32'h0);

    // JC not taken, then taken
    sif.bus_in = 8'h7A;
    sif.flag_c = 1'b0;
    adv(); adv();
    check("jc_nt_ctrl", 32'(sif.ctrl), 32'h0000);
    adv();
    check("jc_nt_wrap", 32'(sif.step), 32'h0);
    sif.flag_c = 1'b1;
    adv(); adv();
    check("jc_t_ctrl",    32'(sif.ctrl),    32'h0802);
    check("jc_t_operand", 32'(sif.operand), 32'hA);
    adv();

    // Single step: held request gives one advance, tick ignored.
    sif.mode     = 1'b1;
    sif.step_req = 1'b1;
    ce_cnt       = 0;
    for (int i = 0; i < 20; i++) begin
      sif.tick = (i % 4 == 0);
      #1;
      if (sif.ce) ce_cnt++;
      @(posedge clk);
      #1;
    end
    sif.tick = 1'b0;
    check("sstep_ce_count", 32'(ce_cnt),   32'd1);
    check("sstep_step",     32'(sif.step), 32'h1);
    sif.step_req = 1'b0;
    sif.mode     = 1'b0;

    // Reset in the middle of ADD at step 3.
    sif.bus_in = 8'h2C;
    adv(); adv();
    check("add_step3", 32'(sif.step), 32'h3);
    check("add_ctrl3", 32'(sif.ctrl), 32'h1020);
    rst_n = 1'b0;
    #1;
    check("arst_step",    32'(sif.step),    32'h0);
    check("arst_operand", 32'(sif.operand), 32'h0);
    check("arst_halted",  32'(sif.halted),  32'h0);
    cyc(1);
    rst_n = 1'b1;
    adv();
    check("resume_step", 32'(sif.step), 32'h1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      sif.tick     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) sif.mode = ~sif.mode;
      sif.step_req = ($urandom_range(0, 2) == 0);
      sif.bus_in   = 8'($urandom_range(0, 255));
      sif.flag_c   = 1'($urandom_range(0, 1));
      sif.flag_z   = 1'($urandom_range(0, 1));
      rst_n        = ($urandom_range(0, 79) != 0);
      cyc(1);
    end
    rst_n        = 1'b1;
    sif.tick     = 1'b0;
    sif.step_req = 1'b0;
    sif.mode     = 1'b0;
    pulse_reset();

    // Halt: HLT word, then frozen with no ce.
    sif.bus_in = 8'hF0;
    adv(); adv();
    check("hlt_ctrl", 32'(sif.ctrl), 32'h8000);
    adv();
    check("hlt_halted", 32'(sif.halted), 32'h1);
    check("hlt_ctrl0",  32'(sif.ctrl),   32'h0000);
    check("hlt_step",   32'(sif.step),   32'h2);
    ce_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      sif.tick     = 1'b1;
      sif.step_req = (i % 2 == 0);
      sif.mode     = (i >= 10);
      #1;
      if (sif.ce) ce_cnt++;
      @(posedge clk);
      #1;
    end
    check("hlt_no_ce", 32'(ce_cnt), 32'd0);

    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
